vdu_mem_arbiter: RTL and testbench
==================================

VDU_MEM_ARBITER -- requirements
Module: vdu_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the width of every address port.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of every data port.
REQ-003 clk_pix  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_pix  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 vdu_read_en  in  1  SHALL request a VDU read of the memory port in the current cycle.
REQ-006 vdu_read_addr  in  ADDR_W  SHALL give the VDU read address.
REQ-007 vdu_data  out  DATA_W  SHALL return VDU read data one cycle after vdu_read_en.
REQ-008 cpu_req  in  1  SHALL be a level request, held by the CPU until cpu_ack.
REQ-009 cpu_we, cpu_addr[ADDR_W], cpu_wdata[DATA_W]  in  SHALL give the access type, address and write data; they are valid while cpu_req is high.
REQ-010 cpu_ack  out  1  SHALL pulse for one cycle on access completion.
REQ-011 cpu_rdata  out  DATA_W  SHALL hold the read data, valid in the cpu_ack cycle.
REQ-012 mem_en, mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]  out  SHALL drive the single-port synchronous RAM.
REQ-013 mem_rdata  in  DATA_W  SHALL carry RAM read data, valid one cycle after mem_en.
REQ-014 max_wait  out  8  SHALL report the largest number of cycles a CPU request has been blocked by the VDU.

Function
REQ-015 The VDU SHALL have absolute priority; any cycle with vdu_read_en=1 SHALL drive mem_en=1, mem_we=0, mem_addr=vdu_read_addr combinationally.
REQ-016 vdu_data SHALL be mem_rdata passed through combinationally; VDU read latency SHALL be exactly 1 cycle and SHALL never stall.
REQ-017 FSM states SHALL be IDLE, PEND, DATA, ACK.
REQ-018 IDLE: when cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata; clear wait_cnt; go to PEND.
REQ-019 PEND with vdu_read_en=1: stay in PEND; increment wait_cnt, saturating at 255.
REQ-020 PEND with vdu_read_en=0: drive mem_en=1 and the latched we, addr and wdata; go to DATA.
REQ-021 DATA: register cpu_rdata<=mem_rdata for reads only (hold for writes); set cpu_ack<=1; go to ACK.
REQ-022 ACK: cpu_ack=1 for exactly this cycle; update max_wait<=max(max_wait, wait_cnt); ignore cpu_req; go to IDLE.
REQ-023 Uncontended latency SHALL be 3 cycles: cpu_req sampled in cycle 0, RAM access in cycle 1, cpu_ack in cycle 3. Each blocking VDU cycle SHALL add exactly 1 cycle.
REQ-024 In any cycle with neither VDU nor CPU issue, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-025 CPU input changes after latching SHALL NOT affect the in-flight access.
REQ-026 A VDU read and a CPU issue SHALL never be driven in the same cycle.

Reset
REQ-027 While rst_pix=0: state=IDLE, cpu_ack=0, cpu_rdata=0, wait_cnt=0, max_wait=0, and the latched request is discarded.
REQ-028 A reset during PEND, DATA or ACK SHALL abort the access with no ack; the requester SHALL reissue it.
REQ-029 mem_en SHALL still follow vdu_read_en during reset; the VDU path is combinational.

Structure
REQ-030 The FSM state enum and the default widths SHALL live in package mk14_vdu_pkg.
REQ-031 No sub-module SHALL be used; the block is a single FSM plus datapath registers.

Verification
REQ-032 Idle VDU, CPU write 0x5A to 0x0200: mem_we=1 in cycle 1, cpu_ack in cycle 3; a following read of 0x0200 returns cpu_rdata=0x5A.
REQ-033 vdu_read_en high for cycles 1..4, CPU read issued at cycle 0: CPU issue in cycle 5, cpu_ack in cycle 7, max_wait=4.
REQ-034 vdu_read_en asserted every 8th cycle while CPU reads back-to-back: vdu_data is correct 1 cycle after every VDU read, and no CPU issue coincides with a VDU read.
REQ-035 rst_pix pulsed low during DATA: no cpu_ack, state=IDLE, max_wait=0; a reissued request completes normally.
REQ-036 vdu_read_en held high for 300 cycles: wait_cnt saturates, max_wait=255 after the ack.
REQ-037 cpu_addr and cpu_wdata changed after the IDLE latch: RAM receives the originally latched values.

Source files
------------

// File: rtl/mk14_vdu_pkg.sv
// -----------------------------------------------------------------------------
// mk14_vdu_pkg
// Shared definitions for the VDU/CPU memory arbiter:
//   - default address/data widths of the video memory port
//   - width of the CPU wait counter and max-wait statistic
//   - arbiter FSM state encoding
//   - saturating increment helper for the wait counter
// -----------------------------------------------------------------------------
package mk14_vdu_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 8;
    localparam int WAIT_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

    // Counter sticks at all-ones instead of wrapping back to zero
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vdu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vdu_mem_arbiter
// Shares one single-port synchronous RAM between the video display unit and
// the CPU. The VDU path is purely combinational and always wins; the CPU
// request is latched, held off while the VDU is reading, then issued, and
// acknowledged two cycles after the RAM access.
//
// Ports
//   clk_pix        in   pixel clock, all state on its rising edge
//   rst_pix        in   asynchronous active-low reset
//   vdu_read_en    in   VDU read request for this cycle
//   vdu_read_addr  in   VDU read address
//   vdu_data       out  VDU read data (RAM data, one cycle after the read)
//   cpu_req        in   CPU level request, held until cpu_ack
//   cpu_we         in   CPU access type (1 = write)
//   cpu_addr       in   CPU address
//   cpu_wdata      in   CPU write data
//   cpu_ack        out  one-cycle completion pulse
//   cpu_rdata      out  CPU read data, valid with cpu_ack
//   mem_en         out  RAM enable
//   mem_we         out  RAM write enable
//   mem_addr       out  RAM address
//   mem_wdata      out  RAM write data
//   mem_rdata      in   RAM read data, valid one cycle after mem_en
//   max_wait       out  largest number of cycles the VDU has blocked the CPU
// -----------------------------------------------------------------------------
module vdu_mem_arbiter
    import mk14_vdu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              vdu_read_en,
    input  logic [ADDR_W-1:0] vdu_read_addr,
    output logic [DATA_W-1:0] vdu_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [WAIT_W-1:0] max_wait
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              w_cpu_issue;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] r_max_wait;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;

    // VDU data is the raw RAM output; the RAM's own one-cycle latency is the
    // VDU read latency, so nothing is registered here.
    assign vdu_data  = mem_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign max_wait  = r_max_wait;

    // State register. Reset drops any access in flight back to IDLE.
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and RAM port drive. The CPU only reaches the RAM from PEND
    // in a cycle the VDU leaves free, so the two can never collide. The VDU
    // terms do not depend on state and keep working while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_cpu_issue  = 1'b0;

        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_next_state = PEND;
                end
            end
            PEND: begin
                if (!vdu_read_en) begin
                    w_cpu_issue  = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_next_state = ACK;
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        mem_en    = vdu_read_en | w_cpu_issue;
        mem_we    = w_cpu_issue & r_we;
        mem_addr  = vdu_read_en ? vdu_read_addr : r_addr;
        mem_wdata = r_wdata;
    end

    // Request latch, wait accounting and CPU response registers. The request
    // is captured once in IDLE so later changes on the CPU bus cannot disturb
    // the access. The ack is registered from DATA, so it is high exactly in
    // the ACK cycle.
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= '0;
            r_max_wait  <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_cpu_ack <= (r_state == DATA);

            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we       <= cpu_we;
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_wait_cnt <= '0;
                    end
                end
                PEND: begin
                    if (vdu_read_en) begin
                        r_wait_cnt <= sat_inc(r_wait_cnt);
                    end
                end
                DATA: begin
                    // Writes leave the previous read data visible
                    if (!r_we) begin
                        r_cpu_rdata <= mem_rdata;
                    end
                end
                ACK: begin
                    if (r_wait_cnt > r_max_wait) begin
                        r_max_wait <= r_wait_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdu_mem_arbiter
// Directed bench for vdu_mem_arbiter with a behavioural synchronous RAM.
// Expected VDU data and CPU transactions are queued when driven and checked
// when the arbiter produces them.
// -----------------------------------------------------------------------------
module tb_vdu_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              clk_pix = 1'b0;
    logic              rst_pix;
    logic              vdu_read_en;
    logic [ADDR_W-1:0] vdu_read_addr;
    logic [DATA_W-1:0] vdu_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [7:0]        max_wait;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          issueCyc;
        int          ackCyc;
        bit          issued;
    } cpu_txn_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } vdu_txn_t;

    cpu_txn_t   cpuQ[$];
    vdu_txn_t   vduQ[$];
    bit [7:0]   expWr[int];
    logic [7:0] ram [65536];
    bit         ramWritten [65536];

    int         testsRun = 0;
    int         failCount = 0;
    int         cyc = 0;
    int         reqCyc = 0;
    bit         ackSeen = 0;
    int         vduMode = 0;
    int         winStart = 0;
    int         winLen = 0;
    int         expMax = 0;
    logic [7:0] expCpuRdata = 8'h00;

    vdu_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_pix      (clk_pix),
        .rst_pix      (rst_pix),
        .vdu_read_en  (vdu_read_en),
        .vdu_read_addr(vdu_read_addr),
        .vdu_data     (vdu_data),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .max_wait     (max_wait)
    );

    always #5 clk_pix = ~clk_pix;

    // Power-on contents of the RAM: a fixed address-derived pattern
    function automatic logic [7:0] patt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] expData(input logic [15:0] a);
        return expWr.exists(int'(a)) ? expWr[int'(a)] : patt(a);
    endfunction

    // Single-port synchronous RAM, read-before-write
    always @(posedge clk_pix) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]        <= mem_wdata;
                ramWritten[mem_addr] <= 1'b1;
            end
            mem_rdata <= ramWritten[mem_addr] ? ram[mem_addr] : patt(mem_addr);
        end
    end

    // VDU request pattern for the current test
    function automatic bit vduActive(input int c);
        case (vduMode)
            1:       return ((c - reqCyc) >= winStart) && ((c - reqCyc) < winStart + winLen);
            2:       return (c % 8) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drive the VDU for the current cycle and queue the data it should see
    task automatic setVdu(input bit en);
        vdu_txn_t v;
        vdu_read_en   = en;
        vdu_read_addr = en ? (16'h1000 + 16'(cyc % 256)) : 16'h0000;
        if (en) begin
            v.due  = cyc + 1;
            v.data = expData(vdu_read_addr);
            vduQ.push_back(v);
        end
    endtask

    // Check the RAM port for the current cycle, advance one clock, then
    // check the registered outputs of the new cycle
    task automatic applyStimulus();
        cpu_txn_t t;
        vdu_txn_t v;
        #1;
        if (vdu_read_en) begin
            checkOutput("vdu_mem_ctrl", 32'({mem_en, mem_we}), 32'h2);
            checkOutput("vdu_mem_addr", 32'(mem_addr), 32'(vdu_read_addr));
        end else if (mem_en) begin
            if (cpuQ.size() == 0 || cpuQ[0].issued) begin
                checkOutput("spurious_issue", 32'(mem_en), 32'h0);
            end else begin
                t = cpuQ.pop_front();
                checkOutput("issue_cycle", 32'(cyc), 32'(t.issueCyc));
                checkOutput("issue_we", 32'(mem_we), 32'(t.we));
                checkOutput("issue_addr", 32'(mem_addr), 32'(t.addr));
                if (t.we) begin
                    checkOutput("issue_wdata", 32'(mem_wdata), 32'(t.wdata));
                end
                t.issued = 1'b1;
                cpuQ.push_front(t);
            end
        end else if (mem_we) begin
            checkOutput("idle_mem_we", 32'(mem_we), 32'h0);
        end

        @(posedge clk_pix);
        cyc++;
        #1;
        if (vduQ.size() > 0 && vduQ[0].due == cyc) begin
            v = vduQ.pop_front();
            checkOutput("vdu_data", 32'(vdu_data), 32'(v.data));
        end
        if (cpu_ack) begin
            if (cpuQ.size() == 0) begin
                checkOutput("unexpected_ack", 32'(cpu_ack), 32'h0);
            end else begin
                t = cpuQ.pop_front();
                ackSeen = 1'b1;
                checkOutput("ack_cycle", 32'(cyc), 32'(t.ackCyc));
                checkOutput("ack_after_issue", 32'(t.issued), 32'h1);
                checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(t.rdata));
            end
        end
    endtask

    // One complete CPU access under the current VDU pattern, including the
    // ack cycle, followed by a max_wait check
    task automatic runCpu(input bit we, input logic [15:0] addr, input logic [7:0] wdata, input bit scramble);
        cpu_txn_t t;
        int       issue;
        int       waited;
        int       k;
        reqCyc = cyc;
        issue  = reqCyc + 1;
        while (vduActive(issue)) issue++;
        waited = issue - reqCyc - 1;
        if (waited > 255) waited = 255;

        t.we       = we;
        t.addr     = addr;
        t.wdata    = wdata;
        t.issueCyc = issue;
        t.ackCyc   = issue + 2;
        t.issued   = 1'b0;
        if (we) begin
            expWr[int'(addr)] = wdata;
            t.rdata = expCpuRdata;
        end else begin
            t.rdata     = expData(addr);
            expCpuRdata = t.rdata;
        end
        cpuQ.push_back(t);

        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        ackSeen   = 1'b0;
        k         = 0;
        while (!ackSeen && k < 400) begin
            setVdu(vduActive(cyc));
            if (scramble && cyc != reqCyc) begin
                cpu_addr  = ~addr;
                cpu_wdata = ~wdata;
            end
            applyStimulus();
            k++;
        end
        if (!ackSeen) begin
            checkOutput("ack_timeout", 32'(ackSeen), 32'h1);
            cpuQ.delete();
        end
        cpu_req = 1'b0;
        setVdu(vduActive(cyc));
        applyStimulus();
        if (waited > expMax) expMax = waited;
        checkOutput("max_wait", 32'(max_wait), 32'(expMax));
    endtask

    initial begin
        cpu_txn_t t;

        // Reset with the VDU reading: RAM port must still follow the VDU
        rst_pix   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        setVdu(1'b1);
        applyStimulus();
        setVdu(1'b0);
        applyStimulus();
        checkOutput("reset_cpu_ack", 32'(cpu_ack), 32'h0);
        checkOutput("reset_cpu_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("reset_max_wait", 32'(max_wait), 32'h0);
        rst_pix = 1'b1;
        applyStimulus();

        // Uncontended write then read-back
        vduMode = 0;
        runCpu(1'b1, 16'h0200, 8'h5A, 1'b0);
        runCpu(1'b0, 16'h0200, 8'h00, 1'b0);

        // CPU bus scrambled after the latch; read-back proves the latched values
        runCpu(1'b1, 16'h0400, 8'h3C, 1'b1);
        runCpu(1'b0, 16'h0400, 8'h00, 1'b0);
        runCpu(1'b0, 16'hFBFF, 8'h00, 1'b0);

        // VDU busy for cycles 1..4 of a CPU read
        vduMode  = 1;
        winStart = 1;
        winLen   = 4;
        runCpu(1'b0, 16'h0200, 8'h00, 1'b0);

        // VDU every 8th cycle with back-to-back CPU reads and a write
        vduMode = 2;
        for (int i = 0; i < 8; i++) begin
            runCpu(i == 3, 16'h0200 + 16'(i * 64), 8'h11 * 8'(i), 1'b0);
        end

        // Reset during DATA aborts the access with no ack
        vduMode = 0;
        t.we       = 1'b0;
        t.addr     = 16'h0200;
        t.wdata    = 8'h00;
        t.rdata    = expData(16'h0200);
        t.issueCyc = cyc + 1;
        t.ackCyc   = cyc + 3;
        t.issued   = 1'b0;
        cpuQ.push_back(t);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0200;
        setVdu(1'b0);
        applyStimulus();
        applyStimulus();
        #2;
        rst_pix = 1'b0;
        cpu_req = 1'b0;
        #2;
        checkOutput("abort_cpu_ack", 32'(cpu_ack), 32'h0);
        checkOutput("abort_cpu_rdata", 32'(cpu_rdata), 32'h0);
        checkOutput("abort_max_wait", 32'(max_wait), 32'h0);
        #1;
        rst_pix = 1'b1;
        cpuQ.delete();
        expMax      = 0;
        expCpuRdata = 8'h00;
        repeat (4) applyStimulus();
        runCpu(1'b0, 16'h0200, 8'h00, 1'b0);

        // VDU hogs the RAM for 300 cycles: wait count saturates
        vduMode  = 1;
        winStart = 1;
        winLen   = 300;
        runCpu(1'b0, 16'h0400, 8'h00, 1'b0);

        vduMode = 0;
        setVdu(1'b0);
        repeat (2) applyStimulus();
        checkOutput("vdu_queue_drained", 32'(vduQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
